// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 set-2 constants, decoder state encoding and event width
package ps2_pkg;
  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_BAT  = 8'hAA;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;
  localparam int EVT_W = 10;
  // bit0 = extended prefix seen, bit1 = break prefix seen
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXT     = 2'b01,
    ST_BRK     = 2'b10,
    ST_EXT_BRK = 2'b11
  } ps2_state_e;
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: registered first-word-fall-through FIFO for key events
//   push/din   write side; push is ignored when full unless a pop happens in the same cycle
//   pop/dout   read side; dout is the head (zero when empty), pop ignored when empty
//   valid      non-empty; count occupancy 0..DEPTH; full count==DEPTH
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_pop, do_push;
  assign valid = cnt_q != '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign do_pop = pop & valid;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (!full | do_pop);
  assign dout = valid ? mem_q[rd_q] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: decodes PS/2 set-2 bytes into {ext, brk, code} events and queues them
//   rx_data/rx_valid/rx_err  byte stream and error strobe from the PS/2 receiver
//   evt_code/ext/brk/valid   head event, popped with evt_ready
//   last_code                most recent non-prefix code byte
//   count/overflow           FIFO occupancy and sticky drop flag (overflow_clr clears)
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit DROP_BREAK = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_err,
  output logic [7:0]             evt_code,
  output logic                   evt_ext,
  output logic                   evt_brk,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             last_code,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   overflow_clr
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_e st_q, st_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] last_q, last_d;
  logic ovf_q, ovf_d;
  logic emit, push, full, drop;
  logic [EVT_W-1:0] head;
  always_comb begin
    st_d = st_q;
    emit = 1'b0;
    if (rx_err) st_d = ST_IDLE;
    else if (rx_valid) begin
      if (rx_data == PS2_ERR0 || rx_data == PS2_ERR1) st_d = ST_IDLE;
      else if (rx_data == PS2_EXT) st_d = st_q[1] ? ST_EXT_BRK : ST_EXT;
      else if (rx_data == PS2_BRK) st_d = st_q[0] ? ST_EXT_BRK : ST_BRK;
      else begin
        emit = 1'b1;
        st_d = ST_IDLE;
      end
    end else if (st_q != ST_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) st_d = ST_IDLE;
  end
  // timer only runs while a prefix is waiting for its next byte
  assign timer_d = (st_d == ST_IDLE || rx_valid) ? '0 : timer_q + TW'(1);
  assign last_d = emit ? rx_data : last_q;
  assign push = emit & !(DROP_BREAK & st_q[1]);
  assign drop = push & full & !(evt_valid & evt_ready);
  assign ovf_d = drop ? 1'b1 : overflow_clr ? 1'b0 : ovf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= ST_IDLE;
      timer_q <= '0;
      last_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      timer_q <= timer_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
    end
  end
  ps2_evt_fifo #(.WIDTH(EVT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({st_q[0], st_q[1], rx_data}),
    .pop(evt_ready),
    .dout(head),
    .valid(evt_valid),
    .count(count),
    .full(full)
  );
  assign {evt_ext, evt_brk, evt_code} = head;
  assign last_code = last_q;
  assign overflow = ovf_q;
endmodule
